// File: rtl/water_level_tracker_pkg.sv
// Shared level encodings, default thresholds and a threshold-ordering check
// for the water level tracker.
package water_level_tracker_pkg;

  typedef enum logic [1:0] {
    LVL_C = 2'b00,
    LVL_L = 2'b01,
    LVL_M = 2'b10,
    LVL_H = 2'b11
  } level_e;

  localparam int DEF_COUNT_W = 3;
  localparam int DEF_L_RISE  = 1;
  localparam int DEF_M_RISE  = 5;
  localparam int DEF_H_RISE  = 7;
  localparam int DEF_L_FALL  = 0;
  localparam int DEF_M_FALL  = 2;
  localparam int DEF_H_FALL  = 5;

  function automatic logic thresholds_legal(input int cw, input int lr, input int mr,
                                            input int hr, input int lf, input int mf,
                                            input int hf);
    return (lf < lr) && (mf < mr) && (hf < hr) &&
           (lr <= mr) && (mr <= hr) && (hr <= ((2 ** cw) - 1));
  endfunction

endpackage

// File: rtl/water_level_tracker_if.sv
// Pulse inputs and level/volume outputs of the water level tracker.
interface water_level_tracker_if #(parameter int COUNT_W = 3);

  logic               enable;
  logic               fill;
  logic               drain;
  logic [COUNT_W-1:0] count;
  logic               direction;
  logic [1:0]         water_box;
  logic               level_chg;
  logic               overflow;
  logic               underflow;
  logic               pump_req;

  modport master (
    output enable, fill, drain,
    input  count, direction, water_box, level_chg, overflow, underflow, pump_req
  );

  modport slave (
    input  enable, fill, drain,
    output count, direction, water_box, level_chg, overflow, underflow, pump_req
  );

endinterface

// File: rtl/water_level_tracker_fsm.sv
// Hysteretic C/L/M/H level state machine driven by the registered volume
// count; also produces the level-change pulse and the pump request.
module water_level_fsm
  import water_level_tracker_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COUNT_W-1:0] count,
  input  logic [COUNT_W-1:0] l_rise,
  input  logic [COUNT_W-1:0] m_rise,
  input  logic [COUNT_W-1:0] h_rise,
  input  logic [COUNT_W-1:0] l_fall,
  input  logic [COUNT_W-1:0] m_fall,
  input  logic [COUNT_W-1:0] h_fall,
  output logic [1:0]         water_box,
  output logic               level_chg,
  output logic               pump_req
);

  level_e state_r;
  level_e next_s;
  logic   level_chg_r;
  logic   pump_req_r;
  logic   pump_next_s;

  // Next level (single step, hysteresis band holds) and pump command.
  always_comb begin
    next_s      = state_r;
    pump_next_s = pump_req_r;
    if (enable) begin
      case (state_r)
        LVL_C: begin
          if (count >= l_rise) next_s = LVL_L;
          else                 next_s = LVL_C;
        end
        LVL_L: begin
          if (count >= m_rise)      next_s = LVL_M;
          else if (count <= l_fall) next_s = LVL_C;
          else                      next_s = LVL_L;
        end
        LVL_M: begin
          if (count >= h_rise)      next_s = LVL_H;
          else if (count <= m_fall) next_s = LVL_L;
          else                      next_s = LVL_M;
        end
        LVL_H: begin
          if (count <= h_fall) next_s = LVL_M;
          else                 next_s = LVL_H;
        end
        default: next_s = LVL_C;
      endcase
      case (next_s)
        LVL_C, LVL_L: pump_next_s = 1'b1;
        LVL_H:        pump_next_s = 1'b0;
        default:      pump_next_s = pump_req_r;
      endcase
    end else begin
      next_s      = state_r;
      pump_next_s = pump_req_r;
    end
  end

  // Level, change pulse and pump registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LVL_C;
      level_chg_r <= 1'b0;
      pump_req_r  <= 1'b1;
    end else begin
      state_r     <= next_s;
      level_chg_r <= (next_s != state_r);
      pump_req_r  <= pump_next_s;
    end
  end

  assign water_box = state_r;
  assign level_chg = level_chg_r;
  assign pump_req  = pump_req_r;

endmodule

// File: rtl/water_level_tracker.sv
// Saturating fill/drain volume counter with direction tracking and flag
// pulses, feeding the hysteretic level state machine.
module water_level_tracker
  import water_level_tracker_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int L_RISE  = DEF_L_RISE,
  parameter int M_RISE  = DEF_M_RISE,
  parameter int H_RISE  = DEF_H_RISE,
  parameter int L_FALL  = DEF_L_FALL,
  parameter int M_FALL  = DEF_M_FALL,
  parameter int H_FALL  = DEF_H_FALL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  water_level_tracker_if.slave  bus
);

  localparam logic [COUNT_W-1:0] CMAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);

  generate
    if (!thresholds_legal(COUNT_W, L_RISE, M_RISE, H_RISE, L_FALL, M_FALL, H_FALL)) begin : g_bad_thresholds
      $error("water_level_tracker: illegal threshold ordering");
    end
  endgenerate

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_next_s;
  logic               dir_r;
  logic               dir_next_s;
  logic               overflow_r;
  logic               overflow_s;
  logic               underflow_r;
  logic               underflow_s;

  // Counter update: simultaneous fill and drain cancel out.
  always_comb begin
    count_next_s = count_r;
    dir_next_s   = dir_r;
    overflow_s   = 1'b0;
    underflow_s  = 1'b0;
    if (bus.enable && bus.fill && !bus.drain) begin
      dir_next_s = 1'b1;
      if (count_r == CMAX) overflow_s = 1'b1;
      else                 count_next_s = count_r + ONE;
    end else if (bus.enable && bus.drain && !bus.fill) begin
      dir_next_s = 1'b0;
      if (count_r == {COUNT_W{1'b0}}) underflow_s = 1'b1;
      else                            count_next_s = count_r - ONE;
    end else begin
      count_next_s = count_r;
      dir_next_s   = dir_r;
    end
  end

  // Counter, direction and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {COUNT_W{1'b0}};
      dir_r       <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      dir_r       <= dir_next_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
    end
  end

  water_level_fsm #(.COUNT_W(COUNT_W)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (bus.enable),
    .count     (count_r),
    .l_rise    (COUNT_W'(L_RISE)),
    .m_rise    (COUNT_W'(M_RISE)),
    .h_rise    (COUNT_W'(H_RISE)),
    .l_fall    (COUNT_W'(L_FALL)),
    .m_fall    (COUNT_W'(M_FALL)),
    .h_fall    (COUNT_W'(H_FALL)),
    .water_box (bus.water_box),
    .level_chg (bus.level_chg),
    .pump_req  (bus.pump_req)
  );

  assign bus.count     = count_r;
  assign bus.direction = dir_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule

// File: tb/tb_water_level_tracker.sv
// Bench for water_level_tracker: default 3-bit instance plus a 4-bit instance
// with alternate thresholds, both checked every cycle against a level model.
module tb_water_level_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  water_level_tracker_if #(.COUNT_W(3)) bus_a ();
  water_level_tracker_if #(.COUNT_W(4)) bus_b ();

  water_level_tracker #(.COUNT_W(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  water_level_tracker #(
    .COUNT_W(4), .L_RISE(2), .M_RISE(8), .H_RISE(15),
    .L_FALL(1), .M_FALL(5), .H_FALL(12)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int m_cnt[2], m_dir[2], m_lvl[2], m_pump[2], m_chg[2], m_ovf[2], m_unf[2];
  int cmax[2]    = '{7, 15};
  int rise[2][3] = '{'{1, 5, 7}, '{2, 8, 15}};
  int fall[2][3] = '{'{0, 2, 5}, '{1, 5, 12}};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_dir[i] = 0; m_lvl[i] = 0; m_pump[i] = 1;
      m_chg[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  // Level moves from the count held before this edge; count then moves.
  task automatic model_step(input int i, input bit en, input bit f, input bit d);
    int nl;
    m_chg[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    if (en) begin
      nl = m_lvl[i];
      if (m_lvl[i] < 3 && m_cnt[i] >= rise[i][m_lvl[i]]) nl = m_lvl[i] + 1;
      else if (m_lvl[i] > 0 && m_cnt[i] <= fall[i][m_lvl[i]-1]) nl = m_lvl[i] - 1;
      m_chg[i] = (nl != m_lvl[i]) ? 1 : 0;
      m_lvl[i] = nl;
      if (nl <= 1) m_pump[i] = 1;
      else if (nl == 3) m_pump[i] = 0;
      if (f && !d) begin
        m_dir[i] = 1;
        if (m_cnt[i] == cmax[i]) m_ovf[i] = 1; else m_cnt[i]++;
      end else if (d && !f) begin
        m_dir[i] = 0;
        if (m_cnt[i] == 0) m_unf[i] = 1; else m_cnt[i]--;
      end
    end
  endtask

  task automatic check_out(input string who, input int i, input logic [7:0] cnt,
                           input logic dir, input logic [1:0] wb, input logic chg,
                           input logic ovf, input logic unf, input logic pump);
    chk({who, ".count"},     cnt,           8'(m_cnt[i]));
    chk({who, ".direction"}, {7'b0, dir},   8'(m_dir[i]));
    chk({who, ".water_box"}, {6'b0, wb},    8'(m_lvl[i]));
    chk({who, ".level_chg"}, {7'b0, chg},   8'(m_chg[i]));
    chk({who, ".overflow"},  {7'b0, ovf},   8'(m_ovf[i]));
    chk({who, ".underflow"}, {7'b0, unf},   8'(m_unf[i]));
    chk({who, ".pump_req"},  {7'b0, pump},  8'(m_pump[i]));
  endtask

  task automatic check_all();
    check_out("A", 0, {5'b0, bus_a.count}, bus_a.direction, bus_a.water_box,
              bus_a.level_chg, bus_a.overflow, bus_a.underflow, bus_a.pump_req);
    check_out("B", 1, {4'b0, bus_b.count}, bus_b.direction, bus_b.water_box,
              bus_b.level_chg, bus_b.overflow, bus_b.underflow, bus_b.pump_req);
  endtask

  task automatic cycle2(input bit ea, input bit fa, input bit da,
                        input bit eb, input bit fb, input bit db);
    bus_a.enable = ea; bus_a.fill = fa; bus_a.drain = da;
    bus_b.enable = eb; bus_b.fill = fb; bus_b.drain = db;
    model_step(0, ea, fa, da);
    model_step(1, eb, fb, db);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cycle(input bit en, input bit f, input bit d);
    cycle2(en, f, d, en, f, d);
  endtask

  int chg_seen;

  initial begin
    rst_n = 1'b0;
    bus_a.enable = 1'b0; bus_a.fill = 1'b0; bus_a.drain = 1'b0;
    bus_b.enable = 1'b0; bus_b.fill = 1'b0; bus_b.drain = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset.pump", {7'b0, bus_a.pump_req}, 8'd1);
    rst_n = 1'b1;

    // Fill ramp 0 -> 7, plus one idle cycle so the final level shows.
    chg_seen = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, (k < 7), 1'b0);
      chg_seen += int'(bus_a.level_chg);
    end
    chk("ramp.count", {5'b0, bus_a.count}, 8'd7);
    chk("ramp.level", {6'b0, bus_a.water_box}, 8'd3);
    chk("ramp.pump", {7'b0, bus_a.pump_req}, 8'd0);
    chk("ramp.chg_pulses", 8'(chg_seen), 8'd3);

    // Drain back through the hysteresis bands.
    repeat (7) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("drain.level", {6'b0, bus_a.water_box}, 8'd0);

    // Saturation at both ends.
    cycle(1'b1, 1'b0, 1'b1);
    chk("sat.underflow", {7'b0, bus_a.underflow}, 8'd1);
    repeat (7) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("sat.overflow", {7'b0, bus_a.overflow}, 8'd1);
    chk("sat.count", {5'b0, bus_a.count}, 8'd7);
    cycle(1'b1, 1'b0, 1'b0);
    chk("sat.pulse_len", {7'b0, bus_a.overflow}, 8'd0);

    // Simultaneous fill+drain at 3, then frozen while disabled.
    repeat (4) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("simul.count", {5'b0, bus_a.count}, 8'd3);
    chk("simul.dir", {7'b0, bus_a.direction}, 8'd0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    chk("disabled.count", {5'b0, bus_a.count}, 8'd3);

    // Asynchronous reset mid-cycle at count 4.
    cycle(1'b1, 1'b1, 1'b0);
    chk("pre_rst.count", {5'b0, bus_a.count}, 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic, independent per instance.
    for (int k = 0; k < 400; k++) begin
      cycle2(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Full 0 -> 15 -> 0 sweep on the 4-bit instance.
    repeat (20) cycle(1'b1, 1'b0, 1'b1);
    repeat (16) cycle2(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sweep.peak_level", {6'b0, bus_b.water_box}, 8'd3);
    chk("sweep.peak_count", {4'b0, bus_b.count}, 8'd15);
    repeat (17) cycle2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("sweep.end_level", {6'b0, bus_b.water_box}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
